poly_voice_scheduler: RTL and testbench

//  Parametrised successor to the fixed six-voice generator. Allocates note events to NUM_VOICES external

---
 rtl/synth_pkg.sv | 29 ++
 rtl/voice_mixer.sv | 133 +++++++++++++
 rtl/poly_voice_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_poly_voice_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared widths, mixer state encoding and the saturation helper for the voice scheduler.
package synth_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned DUR_W    = 6;
  localparam int unsigned META_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } mix_state_t;

  // Clamp a signed value into the range of a w-bit two's complement sample.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/voice_mixer.sv
// Sequential mixer: snapshots all voices on a ready strobe, accumulates one voice per
// cycle, then publishes saturated mono/left/right sums with a one-cycle ready pulse.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 6,
  parameter int unsigned SAMPLE_W   = synth_pkg::SAMPLE_W,
  parameter int unsigned MIX_SHIFT  = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_VOICES-1:0]          voice_in_use,
  input  logic [NUM_VOICES-1:0]          voice_sample_ready,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic [SAMPLE_W-1:0]            sample_out_left,
  output logic [SAMPLE_W-1:0]            sample_out_right,
  output logic                           sample_ready,
  output logic                           overrun
);
  import synth_pkg::*;

  localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  mix_state_t                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [SAMPLE_W-1:0]  samples_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0]  samples_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]       in_use_q, in_use_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d, acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0]         mono_q, mono_d, left_q, left_d, right_q, right_d;
  logic                        ready_q, ready_d, overrun_q, overrun_d;
  logic signed [ACC_W-1:0]     cur_ext;
  logic signed [31:0]          mono_wide;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    samples_d = samples_q;
    in_use_d  = in_use_q;
    acc_d     = acc_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    mono_d    = mono_q;
    left_d    = left_q;
    right_d   = right_q;
    ready_d   = 1'b0;
    mono_wide = '0;
    cur_ext   = ACC_W'(samples_q[idx_q]);
    overrun_d = overrun_q | ((state_q != IDLE) & (|voice_sample_ready));

    case (state_q)
      IDLE: begin
        if (|voice_sample_ready) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            samples_d[v] = voice_samples[v*SAMPLE_W +: SAMPLE_W];
          end
          in_use_d = voice_in_use;
          idx_d    = '0;
          acc_d    = '0;
          acc_l_d  = '0;
          acc_r_d  = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (in_use_q[idx_q]) begin
          acc_d = acc_q + cur_ext;
          if (idx_q[0]) begin
            acc_r_d = acc_r_q + cur_ext;
          end else begin
            acc_l_d = acc_l_q + cur_ext;
          end
        end
        // Results are registered on the way into OUT so they line up with the ready pulse.
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          mono_wide = 32'(acc_d) >>> MIX_SHIFT;
          mono_d    = SAMPLE_W'(sat(mono_wide, SAMPLE_W));
          left_d    = SAMPLE_W'(sat(32'(acc_l_d), SAMPLE_W));
          right_d   = SAMPLE_W'(sat(32'(acc_r_d), SAMPLE_W));
          ready_d   = 1'b1;
          state_d   = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      in_use_q  <= '0;
      acc_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mono_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        samples_q[v] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_use_q  <= in_use_d;
      acc_q     <= acc_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      mono_q    <= mono_d;
      left_q    <= left_d;
      right_q   <= right_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      samples_q <= samples_d;
    end
  end

  assign sample_out       = mono_q;
  assign sample_out_left  = left_q;
  assign sample_out_right = right_q;
  assign sample_ready     = ready_q;
  assign overrun          = overrun_q;

endmodule

// File: rtl/poly_voice_scheduler.sv
// Polyphonic voice scheduler: allocates note events to free voices (stealing the oldest
// when enabled), times rest events in beats, and feeds the sequential voice mixer.
module poly_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 6,
  parameter int unsigned SAMPLE_W   = synth_pkg::SAMPLE_W,
  parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
  parameter int unsigned DUR_W      = synth_pkg::DUR_W,
  parameter int unsigned META_W     = synth_pkg::META_W,
  parameter int unsigned AGE_W      = 4,
  parameter int unsigned STEAL_EN   = 1,
  parameter int unsigned MIX_SHIFT  = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           play_enable,
  input  logic                           beat,
  input  logic                           load_count,
  input  logic                           type_signal,
  input  logic [NOTE_W-1:0]              note,
  input  logic [DUR_W-1:0]               duration,
  input  logic [META_W-1:0]              meta,
  input  logic [NUM_VOICES-1:0]          voice_in_use,
  input  logic [NUM_VOICES-1:0]          voice_sample_ready,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  output logic [NUM_VOICES-1:0]          load_new,
  output logic [NOTE_W-1:0]              note_q,
  output logic [DUR_W-1:0]               dur_q,
  output logic [META_W-1:0]              meta_q,
  output logic                           advance,
  output logic                           steal,
  output logic                           drop,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic [SAMPLE_W-1:0]            sample_out_left,
  output logic [SAMPLE_W-1:0]            sample_out_right,
  output logic                           sample_ready,
  output logic                           overrun
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                  note_evt, rest_evt;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic                  steal_q, steal_d, drop_q, drop_d;
  logic [NOTE_W-1:0]     evt_note_q, evt_note_d;
  logic [DUR_W-1:0]      evt_dur_q, evt_dur_d;
  logic [META_W-1:0]     evt_meta_q, evt_meta_d;
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx, old_idx;
  logic [AGE_W-1:0]      old_age;
  logic [DUR_W-1:0]      rest_tgt_q, rest_tgt_d, rest_cnt_q, rest_cnt_d;
  logic                  rest_act_q, rest_act_d, adv_q, adv_d;

  assign note_evt = load_count & ~type_signal;
  assign rest_evt = load_count & type_signal;

  // Voice allocation and age bookkeeping.
  always_comb begin
    load_d     = '0;
    steal_d    = 1'b0;
    drop_d     = 1'b0;
    evt_note_d = evt_note_q;
    evt_dur_d  = evt_dur_q;
    evt_meta_d = evt_meta_q;
    age_d      = age_q;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age_q[0];

    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_in_use[v]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = IDX_W'(v);
      end
    end

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_in_use[v]) begin
        age_d[v] = '0;
      end
    end

    if (note_evt) begin
      evt_note_d = note;
      evt_dur_d  = duration;
      evt_meta_d = meta;
      if (free_found) begin
        load_d[free_idx] = 1'b1;
      end else if (STEAL_EN != 0) begin
        load_d[old_idx] = 1'b1;
        steal_d         = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_d[v]) begin
          age_d[v] = '0;
        end else if (voice_in_use[v] && (age_q[v] != {AGE_W{1'b1}})) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
    end
  end

  // Rest timer: evaluated on next-state values so a zero target fires the following cycle.
  always_comb begin
    rest_tgt_d = rest_tgt_q;
    rest_cnt_d = rest_cnt_q;
    rest_act_d = rest_act_q;
    adv_d      = 1'b0;
    if (rest_evt) begin
      rest_tgt_d = duration;
      rest_cnt_d = '0;
      rest_act_d = 1'b1;
    end else if (rest_act_q && play_enable && beat) begin
      rest_cnt_d = rest_cnt_q + 1'b1;
    end
    if (rest_act_d && (rest_cnt_d == rest_tgt_d)) begin
      adv_d      = 1'b1;
      rest_act_d = 1'b0;
      rest_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q     <= '0;
      steal_q    <= 1'b0;
      drop_q     <= 1'b0;
      evt_note_q <= '0;
      evt_dur_q  <= '0;
      evt_meta_q <= '0;
      rest_tgt_q <= '0;
      rest_cnt_q <= '0;
      rest_act_q <= 1'b0;
      adv_q      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_q[v] <= '0;
      end
    end else begin
      load_q     <= load_d;
      steal_q    <= steal_d;
      drop_q     <= drop_d;
      evt_note_q <= evt_note_d;
      evt_dur_q  <= evt_dur_d;
      evt_meta_q <= evt_meta_d;
      rest_tgt_q <= rest_tgt_d;
      rest_cnt_q <= rest_cnt_d;
      rest_act_q <= rest_act_d;
      adv_q      <= adv_d;
      age_q      <= age_d;
    end
  end

  assign load_new = load_q;
  assign steal    = steal_q;
  assign drop     = drop_q;
  assign note_q   = evt_note_q;
  assign dur_q    = evt_dur_q;
  assign meta_q   = evt_meta_q;
  assign advance  = adv_q;

  voice_mixer #(
    .NUM_VOICES (NUM_VOICES),
    .SAMPLE_W   (SAMPLE_W),
    .MIX_SHIFT  (MIX_SHIFT)
  ) u_mixer (
    .clk                (clk),
    .reset_n            (reset_n),
    .voice_in_use       (voice_in_use),
    .voice_sample_ready (voice_sample_ready),
    .voice_samples      (voice_samples),
    .sample_out         (sample_out),
    .sample_out_left    (sample_out_left),
    .sample_out_right   (sample_out_right),
    .sample_ready       (sample_ready),
    .overrun            (overrun)
  );

endmodule

// File: tb/tb_poly_voice_scheduler.sv
// Self-checking bench for poly_voice_scheduler: allocation/steal/drop, rest timing and mixer.
module tb_poly_voice_scheduler;

  localparam int NV = 6;
  localparam int SW = 16;

  typedef logic signed [SW-1:0] samp_arr_t [NV];

  typedef struct {
    logic [NV-1:0] load;
    logic          steal;
    logic [NV-1:0] load_ns;
    logic          drop_ns;
    logic [5:0]    note;
    logic [5:0]    dur;
  } alloc_exp_t;

  typedef struct {
    logic signed [SW-1:0] mono;
    logic signed [SW-1:0] l;
    logic signed [SW-1:0] r;
  } mix_exp_t;

  logic clk;
  logic reset_n, play_enable, beat, load_count, type_signal;
  logic [5:0] note, duration;
  logic [2:0] meta;
  logic [NV-1:0] voice_in_use, voice_sample_ready;
  logic [NV*SW-1:0] voice_samples;

  logic [NV-1:0] load_new, load_new_ns;
  logic [5:0] note_q, dur_q, note_q_ns, dur_q_ns;
  logic [2:0] meta_q, meta_q_ns;
  logic advance, steal, drop, advance_ns, steal_ns, drop_ns;
  logic [SW-1:0] sample_out, sample_out_left, sample_out_right;
  logic [SW-1:0] sample_out_ns, sample_out_left_ns, sample_out_right_ns;
  logic sample_ready, overrun, sample_ready_ns, overrun_ns;

  int n_checks = 0;
  int n_fail   = 0;
  int age_m [NV];
  alloc_exp_t alloc_q [$];
  mix_exp_t   mix_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  poly_voice_scheduler #(.NUM_VOICES(NV), .STEAL_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable), .beat(beat),
    .load_count(load_count), .type_signal(type_signal), .note(note), .duration(duration),
    .meta(meta), .voice_in_use(voice_in_use), .voice_sample_ready(voice_sample_ready),
    .voice_samples(voice_samples), .load_new(load_new), .note_q(note_q), .dur_q(dur_q),
    .meta_q(meta_q), .advance(advance), .steal(steal), .drop(drop), .sample_out(sample_out),
    .sample_out_left(sample_out_left), .sample_out_right(sample_out_right),
    .sample_ready(sample_ready), .overrun(overrun)
  );

  poly_voice_scheduler #(.NUM_VOICES(NV), .STEAL_EN(0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable), .beat(beat),
    .load_count(load_count), .type_signal(type_signal), .note(note), .duration(duration),
    .meta(meta), .voice_in_use(voice_in_use), .voice_sample_ready(voice_sample_ready),
    .voice_samples(voice_samples), .load_new(load_new_ns), .note_q(note_q_ns), .dur_q(dur_q_ns),
    .meta_q(meta_q_ns), .advance(advance_ns), .steal(steal_ns), .drop(drop_ns),
    .sample_out(sample_out_ns), .sample_out_left(sample_out_left_ns),
    .sample_out_right(sample_out_right_ns), .sample_ready(sample_ready_ns), .overrun(overrun_ns)
  );

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Drive one note event, model the allocation and queue the expectation.
  task automatic drive_note(input logic [NV-1:0] iu, input logic [5:0] nt);
    alloc_exp_t e;
    int fr, old;
    @(negedge clk);
    voice_in_use = iu;
    load_count   = 1'b1;
    type_signal  = 1'b0;
    note         = nt;
    duration     = nt ^ 6'h2A;
    meta         = nt[2:0];
    for (int v = 0; v < NV; v++) if (!iu[v]) age_m[v] = 0;
    fr = -1;
    for (int v = NV - 1; v >= 0; v--) if (!iu[v]) fr = v;
    old = 0;
    for (int v = 1; v < NV; v++) if (age_m[v] > age_m[old]) old = v;
    e.load = '0; e.load_ns = '0; e.steal = 1'b0; e.drop_ns = 1'b0;
    e.note = nt; e.dur = nt ^ 6'h2A;
    if (fr >= 0) begin
      e.load[fr] = 1'b1; e.load_ns[fr] = 1'b1;
    end else begin
      e.load[old] = 1'b1; e.steal = 1'b1; e.drop_ns = 1'b1;
    end
    for (int v = 0; v < NV; v++)
      if (iu[v]) age_m[v] = e.load[v] ? 0 : ((age_m[v] < 15) ? age_m[v] + 1 : 15);
    alloc_q.push_back(e);
    @(negedge clk);
    load_count = 1'b0;
  endtask

  // Issue a mixer ready strobe and queue the modelled mix.
  task automatic start_mix(input samp_arr_t s, input logic [NV-1:0] iu);
    mix_exp_t e;
    int m, l, r;
    @(negedge clk);
    for (int v = 0; v < NV; v++) voice_samples[v*SW +: SW] = s[v];
    voice_in_use       = iu;
    voice_sample_ready = 6'b000001;
    m = 0; l = 0; r = 0;
    for (int v = 0; v < NV; v++) begin
      if (iu[v]) begin
        m += int'(s[v]);
        if (v % 2 == 0) l += int'(s[v]); else r += int'(s[v]);
      end
    end
    e.mono = SW'(sat16(m)); e.l = SW'(sat16(l)); e.r = SW'(sat16(r));
    mix_q.push_back(e);
  endtask

  // Wait (bounded) for sample_ready; optionally inject an extra strobe at cycle inject_at.
  task automatic wait_mix(input int inject_at, output int lat);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (k == inject_at) voice_sample_ready = 6'b100000;
      else voice_sample_ready = '0;
      if (sample_ready === 1'b1) lat = k;
    end
    voice_sample_ready = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; play_enable = 1'b0; beat = 1'b0; load_count = 1'b0; type_signal = 1'b0;
    note = '0; duration = '0; meta = '0; voice_in_use = '0; voice_sample_ready = '0;
    voice_samples = '0;
    for (int v = 0; v < NV; v++) age_m[v] = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (load_new !== 6'b0) begin n_fail++; $display("FAIL reset_load_new: got %b want 0", load_new); end
    n_checks++; if ({steal, drop, advance} !== 3'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {steal, drop, advance}); end
    n_checks++; if ({sample_out, sample_out_left, sample_out_right} !== '0) begin n_fail++; $display("FAIL reset_samples: got %h %h %h want 0", sample_out, sample_out_left, sample_out_right); end
    n_checks++; if ({sample_ready, overrun} !== 2'b0) begin n_fail++; $display("FAIL reset_ready_overrun: got %b want 00", {sample_ready, overrun}); end
    n_checks++; if ({note_q, dur_q, meta_q} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {note_q, dur_q, meta_q}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_allocation();
    alloc_exp_t e;
    drive_note(6'b000101, 6'd17);
    e = alloc_q.pop_front();
    n_checks++; if (load_new !== e.load) begin n_fail++; $display("FAIL alloc_load_new: got %b want %b", load_new, e.load); end
    n_checks++; if (note_q !== e.note) begin n_fail++; $display("FAIL alloc_note_q: got %0d want %0d", note_q, e.note); end
    n_checks++; if (dur_q !== e.dur) begin n_fail++; $display("FAIL alloc_dur_q: got %0d want %0d", dur_q, e.dur); end
    n_checks++; if ({steal, drop} !== 2'b00) begin n_fail++; $display("FAIL alloc_steal_drop: got %b want 00", {steal, drop}); end
    n_checks++; if (load_new_ns !== e.load_ns) begin n_fail++; $display("FAIL alloc_load_new_ns: got %b want %b", load_new_ns, e.load_ns); end
    @(negedge clk);
    n_checks++; if (load_new !== 6'b0) begin n_fail++; $display("FAIL alloc_one_cycle: got %b want 0", load_new); end
  endtask

  task automatic test_steal_drop();
    alloc_exp_t e;
    logic [NV-1:0] seq [8];
    seq = '{6'b000111, 6'b001000, 6'b001001, 6'b001011, 6'b001111, 6'b011111, 6'b111111, 6'b111111};
    for (int i = 0; i < 8; i++) begin
      drive_note(seq[i], 6'(i + 3));
      e = alloc_q.pop_front();
      n_checks++; if (load_new !== e.load) begin n_fail++; $display("FAIL steal_load_new[%0d]: got %b want %b", i, load_new, e.load); end
      n_checks++; if (steal !== e.steal || drop !== 1'b0) begin n_fail++; $display("FAIL steal_pulse[%0d]: got steal=%b drop=%b want steal=%b drop=0", i, steal, drop, e.steal); end
      n_checks++; if (load_new_ns !== e.load_ns) begin n_fail++; $display("FAIL drop_load_new[%0d]: got %b want %b", i, load_new_ns, e.load_ns); end
      n_checks++; if (drop_ns !== e.drop_ns || steal_ns !== 1'b0) begin n_fail++; $display("FAIL drop_pulse[%0d]: got drop=%b steal=%b want drop=%b steal=0", i, drop_ns, steal_ns, e.drop_ns); end
    end
    @(negedge clk);
    n_checks++; if ({steal, drop_ns} !== 2'b00) begin n_fail++; $display("FAIL steal_drop_one_cycle: got %b want 00", {steal, drop_ns}); end
  endtask

  task automatic test_rest();
    int pulses, at;
    @(negedge clk);
    play_enable = 1'b1; beat = 1'b0; load_count = 1'b1; type_signal = 1'b1; duration = 6'd3;
    pulses = 0; at = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      load_count = 1'b0; type_signal = 1'b0;
      if (advance === 1'b1) begin pulses++; if (at < 0) at = c; end
      beat = (c % 10 == 9);
    end
    beat = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL rest3_pulse_count: got %0d want 1", pulses); end
    n_checks++; if (at !== 30) begin n_fail++; $display("FAIL rest3_pulse_cycle: got %0d want 30", at); end
    // Zero-length rest
    @(negedge clk);
    load_count = 1'b1; type_signal = 1'b1; duration = 6'd0;
    @(negedge clk);
    load_count = 1'b0; type_signal = 1'b0;
    n_checks++; if (advance !== 1'b1) begin n_fail++; $display("FAIL rest0_advance: got %b want 1", advance); end
    @(negedge clk);
    n_checks++; if (advance !== 1'b0) begin n_fail++; $display("FAIL rest0_single: got %b want 0", advance); end
    // Mid-count restart
    load_count = 1'b1; type_signal = 1'b1; duration = 6'd5;
    @(negedge clk); load_count = 1'b0; type_signal = 1'b0; beat = 1'b1;
    @(negedge clk); beat = 1'b0;
    @(negedge clk); beat = 1'b1;
    @(negedge clk); beat = 1'b0; load_count = 1'b1; type_signal = 1'b1; duration = 6'd1;
    @(negedge clk); load_count = 1'b0; type_signal = 1'b0;
    n_checks++; if (advance !== 1'b0) begin n_fail++; $display("FAIL restart_early: got %b want 0", advance); end
    beat = 1'b1;
    @(negedge clk); beat = 1'b0;
    n_checks++; if (advance !== 1'b1) begin n_fail++; $display("FAIL restart_advance: got %b want 1", advance); end
    play_enable = 1'b0;
  endtask

  task automatic test_mixer();
    samp_arr_t pats [4];
    logic [NV-1:0] ius [4];
    mix_exp_t e;
    int lat;
    pats[0] = '{16'sd100, -16'sd50, 16'sd200, 16'sd30, 16'sd0, 16'sd7}; ius[0] = 6'b111111;
    pats[1] = pats[0];                                                 ius[1] = 6'b010101;
    pats[2] = '{16'sd1234, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};    ius[2] = 6'b000000;
    for (int v = 0; v < NV; v++) pats[3][v] = 16'sh8000;               ius[3] = 6'b111111;
    for (int p = 0; p < 4; p++) begin
      start_mix(pats[p], ius[p]);
      wait_mix(0, lat);
      e = mix_q.pop_front();
      n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL mix_latency[%0d]: got %0d want 7", p, lat); end
      n_checks++; if (sample_out !== e.mono) begin n_fail++; $display("FAIL mix_mono[%0d]: got %0d want %0d", p, $signed(sample_out), e.mono); end
      n_checks++; if (sample_out_left !== e.l) begin n_fail++; $display("FAIL mix_left[%0d]: got %0d want %0d", p, $signed(sample_out_left), e.l); end
      n_checks++; if (sample_out_right !== e.r) begin n_fail++; $display("FAIL mix_right[%0d]: got %0d want %0d", p, $signed(sample_out_right), e.r); end
      @(negedge clk);
      n_checks++; if (sample_ready !== 1'b0 || sample_out !== e.mono) begin n_fail++; $display("FAIL mix_hold[%0d]: got ready=%b mono=%0d want ready=0 mono=%0d", p, sample_ready, $signed(sample_out), e.mono); end
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mix_no_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_saturation_overrun();
    samp_arr_t s;
    mix_exp_t e;
    int lat;
    for (int v = 0; v < NV; v++) s[v] = 16'sh7000;
    start_mix(s, 6'b111111);
    wait_mix(3, lat);
    e = mix_q.pop_front();
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL sat_latency: got %0d want 7", lat); end
    n_checks++; if (sample_out !== e.mono) begin n_fail++; $display("FAIL sat_mono: got %h want %h", sample_out, e.mono); end
    n_checks++; if ({sample_out_left, sample_out_right} !== {e.l, e.r}) begin n_fail++; $display("FAIL sat_lr: got %h %h want %h %h", sample_out_left, sample_out_right, e.l, e.r); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    repeat (10) @(negedge clk);
    n_checks++; if (overrun !== 1'b1 || sample_ready !== 1'b0) begin n_fail++; $display("FAIL overrun_sticky: got overrun=%b ready=%b want 1 0", overrun, sample_ready); end
  endtask

  task automatic test_reset_mid_accum();
    samp_arr_t s;
    mix_exp_t e;
    int lat;
    s = '{16'sd100, -16'sd50, 16'sd200, 16'sd30, 16'sd0, 16'sd7};
    start_mix(s, 6'b111111);
    @(negedge clk); voice_sample_ready = '0;
    @(negedge clk);
    mix_q.delete();
    reset_n = 1'b0;
    #1;
    n_checks++; if ({sample_out, sample_out_left, sample_out_right} !== '0) begin n_fail++; $display("FAIL midreset_samples: got %h %h %h want 0", sample_out, sample_out_left, sample_out_right); end
    n_checks++; if ({overrun, sample_ready} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags: got %b want 00", {overrun, sample_ready}); end
    n_checks++; if ({load_new, note_q, dur_q} !== '0) begin n_fail++; $display("FAIL midreset_alloc: got %h want 0", {load_new, note_q, dur_q}); end
    @(negedge clk);
    reset_n = 1'b1;
    start_mix(s, 6'b111111);
    wait_mix(0, lat);
    e = mix_q.pop_front();
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL postreset_latency: got %0d want 7", lat); end
    n_checks++; if ({sample_out, sample_out_left, sample_out_right} !== {e.mono, e.l, e.r}) begin n_fail++; $display("FAIL postreset_mix: got %0d %0d %0d want %0d %0d %0d", $signed(sample_out), $signed(sample_out_left), $signed(sample_out_right), e.mono, e.l, e.r); end
  endtask

  initial begin
    test_reset();
    test_allocation();
    test_steal_drop();
    test_rest();
    test_mixer();
    test_saturation_overrun();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
